fp_add_issue: RTL and testbench
===============================

// Module: fp_add_issue
// PURPOSE
// - Operand issue stage directly upstream of the dual-path FP adder: accepts IEEE-754 binary32 operand pairs plus add/sub op.
// - Unpacks each operand to the adder's internal word {exc[1:0], sign, exp[7:0], frac[22:0]}; hidden bit implied.
// - Buffers pairs in a DEPTH-entry FIFO and presents them with valid/ready, decoupling producers from the adder pipeline.
// PARAMETERS
// - SIZE_MANTISSA  24  mantissa incl. hidden bit (1.M)
// - SIZE_EXPONENT  8   exponent width
// - SIZE_EXC       2   exception field width
// - DEPTH          4   FIFO entries, power of 2, >=2
// - TAG_W          4   opaque tag carried with each pair
// PORTS
// - clk        in   1       clock, all state on rising edge
// - rst        in   1       synchronous active-high reset
// - flush      in   1       synchronous FIFO clear, same effect as rst on FIFO state
// - in_valid   in   1       producer has a pair
// - in_ready   out  1       stage can accept (= !full)
// - in_sub     in   1       1 = A-B, 0 = A+B
// - in_a       in   32      IEEE binary32 operand A
// - in_b       in   32      IEEE binary32 operand B
// - in_tag     in   TAG_W   tag
// - out_valid  out  1       pair available (= !empty)
// - out_ready  in   1       adder side accepts
// - out_sub    out  1       op for adder 'sub' input
// - out_a      out  34      internal-format A (a_number_i)
// - out_b      out  34      internal-format B (b_number_i)
// - out_tag    out  TAG_W   tag of head entry
// - level      out  log2(DEPTH)+1  occupancy
// BEHAVIOUR
// - Internal layout: exc=[33:32], sign=[31], exp=[30:23], frac=[22:0]; codes zero=00, normal=01, infinity=10, NaN=11.
// - Classify: exp==0 -> zero, frac forced 0 (denormals flushed, sign kept); exp==FF,frac==0 -> infinity;
//   exp==FF,frac!=0 -> NaN (frac kept); else normal, exp/frac copied unchanged.
// - Push when in_valid&&in_ready; pop when out_valid&&out_ready; unpacking done before write (stored unpacked).
// - Latency: pair accepted at edge N is visible with out_valid=1 after edge N; no same-cycle bypass when empty.
// - Full: in_ready=0, in_valid ignored, no overwrite. Empty: out_valid=0, out_ready ignored, pointers unchanged.
// - Simultaneous push+pop when 0<level<DEPTH: level unchanged, both pointers advance.
// - At full with pop: in_ready still 0 that cycle (registered full), so push cannot occur.
// - Pointers wrap modulo DEPTH; full/empty via extra pointer MSB.
// - Outputs hold head entry stable while out_valid&&!out_ready; data outputs are don't-care when out_valid=0.
// - rst or flush: pointers=0, level=0, out_valid=0, in_ready=1; a push/pop in that cycle is discarded; flush has priority over push/pop.
// - Reset values: in_ready=1, out_valid=0, level=0, out_a/out_b/out_sub/out_tag=0 (storage cleared on rst only).
// CONFIGURATION
// - FP_ISSUE_STATS_EN defined: adds outputs stat_issued[31:0] (+1 per pop) and stat_special[15:0]
//   (+1 per pushed pair with any operand NaN or infinity); both wrap, cleared by rst, not by flush.
// - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// - Package fp_internal_pkg: exception code localparams, field widths/offsets, internal word width (34), unpack function.
// - One sub-module fp_unpack (combinational binary32 -> internal word), instantiated for A and B; FIFO inline.
// TESTING
// - Push A=0x3F800000, B=0x40000000, sub=0, tag=3; out_ready=1 -> next cycle out_a=0x1_3F800000 layout (exc=01,exp=7F,frac=0), out_b exc=01 exp=80, tag=3.
// - Push 0x00000001, 0x7F800000, 0x7FC00000, 0x80000000 -> exc 00 frac 0 / 10 / 11 frac 400000 / 00 sign 1.
// - out_ready=0, push 4 pairs -> level=4, in_ready=0; 5th in_valid held, not accepted; drain returns pairs in order with original tags.
// - level=2, push and pop same cycle -> level stays 2, order preserved across pointer wrap (run 10 pairs).
// - level=3, assert flush with in_valid=1 -> next cycle level=0, out_valid=0, in_ready=1, flushed pair lost.
// - FP_ISSUE_STATS_EN: issue 5 pairs, 2 with NaN/inf -> stat_issued=5, stat_special=2; rst clears both.

Source files
------------

// File: rtl/fp_internal_pkg.sv
// Shared definitions for the FP adder's internal operand word {exc, sign, exp, frac}
// and the binary32 unpack function used by the issue stage.
package fp_internal_pkg;

  localparam int SIZE_MANTISSA = 24;
  localparam int SIZE_EXPONENT = 8;
  localparam int SIZE_EXC      = 2;
  localparam int FRAC_W        = SIZE_MANTISSA - 1;
  localparam int WORD_W        = SIZE_EXC + 1 + SIZE_EXPONENT + FRAC_W;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = FRAC_W;
  localparam int SIGN_BIT = FRAC_W + SIZE_EXPONENT;
  localparam int EXC_LSB  = SIGN_BIT + 1;

  localparam logic [SIZE_EXC-1:0] EXC_ZERO   = 2'b00;
  localparam logic [SIZE_EXC-1:0] EXC_NORMAL = 2'b01;
  localparam logic [SIZE_EXC-1:0] EXC_INF    = 2'b10;
  localparam logic [SIZE_EXC-1:0] EXC_NAN    = 2'b11;

  // Denormals are flushed to a signed zero; NaN payloads pass through untouched.
  function automatic logic [WORD_W-1:0] unpack_b32(input logic [31:0] v);
    logic                     sign_f;
    logic [SIZE_EXPONENT-1:0] exp_f;
    logic [FRAC_W-1:0]        frac_f;
    logic [FRAC_W-1:0]        frac_o;
    logic [SIZE_EXC-1:0]      exc_o;
    sign_f = v[31];
    exp_f  = v[30:23];
    frac_f = v[22:0];
    if (exp_f == 8'h00) begin
      exc_o  = EXC_ZERO;
      frac_o = 23'd0;
    end else if (exp_f == 8'hFF) begin
      if (frac_f == 23'd0) begin
        exc_o = EXC_INF;
      end else begin
        exc_o = EXC_NAN;
      end
      frac_o = frac_f;
    end else begin
      exc_o  = EXC_NORMAL;
      frac_o = frac_f;
    end
    return {exc_o, sign_f, exp_f, frac_o};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 -> internal adder word converter.
module fp_unpack
  import fp_internal_pkg::*;
(
  input  logic [31:0]       word,
  output logic [WORD_W-1:0] unpacked
);

  // Classify and repack one operand.
  always_comb begin
    unpacked = unpack_b32(word);
  end

endmodule

// File: rtl/fp_add_issue.sv
// Operand issue stage for the dual-path FP adder: unpack both operands and queue them
// in a small FIFO. Optional statistics counters are enabled with FP_ISSUE_STATS_EN.
module fp_add_issue
  import fp_internal_pkg::*;
#(
  parameter int SIZE_MANTISSA = 24,
  parameter int SIZE_EXPONENT = 8,
  parameter int SIZE_EXC      = 2,
  parameter int DEPTH         = 4,
  parameter int TAG_W         = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic                                         in_sub,
  input  logic [31:0]                                  in_a,
  input  logic [31:0]                                  in_b,
  input  logic [TAG_W-1:0]                             in_tag,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_sub,
  output logic [SIZE_EXC+SIZE_EXPONENT+SIZE_MANTISSA-1:0] out_a,
  output logic [SIZE_EXC+SIZE_EXPONENT+SIZE_MANTISSA-1:0] out_b,
  output logic [TAG_W-1:0]                             out_tag,
`ifdef FP_ISSUE_STATS_EN
  output logic [31:0]                                  stat_issued,
  output logic [15:0]                                  stat_special,
`endif
  output logic [$clog2(DEPTH):0]                       level
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] unp_a_s;
  logic [WORD_W-1:0] unp_b_s;

  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              mem_sub_r [DEPTH];
  logic [WORD_W-1:0] mem_a_r   [DEPTH];
  logic [WORD_W-1:0] mem_b_r   [DEPTH];
  logic [TAG_W-1:0]  mem_tag_r [DEPTH];

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  fp_unpack u_unpack_a (.word(in_a), .unpacked(unp_a_s));
  fp_unpack u_unpack_b (.word(in_b), .unpacked(unp_b_s));

  // Full/empty derive from registered pointers, so a pop at full cannot free a slot the same cycle.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    push_s  = in_valid && !full_s;
    pop_s   = !empty_s && out_ready;
  end

  // Pointer update; flush and reset discard any concurrent push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage holds operands already unpacked; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_sub_r[i] <= 1'b0;
        mem_a_r[i]   <= '0;
        mem_b_r[i]   <= '0;
        mem_tag_r[i] <= '0;
      end
    end else if (push_s && !flush) begin
      mem_sub_r[wr_ptr_r[AW-1:0]] <= in_sub;
      mem_a_r[wr_ptr_r[AW-1:0]]   <= unp_a_s;
      mem_b_r[wr_ptr_r[AW-1:0]]   <= unp_b_s;
      mem_tag_r[wr_ptr_r[AW-1:0]] <= in_tag;
    end
  end

  // Head entry and status are read straight from registered state.
  always_comb begin
    in_ready  = !full_s;
    out_valid = !empty_s;
    level     = wr_ptr_r - rd_ptr_r;
    out_sub   = mem_sub_r[rd_ptr_r[AW-1:0]];
    out_a     = mem_a_r[rd_ptr_r[AW-1:0]];
    out_b     = mem_b_r[rd_ptr_r[AW-1:0]];
    out_tag   = mem_tag_r[rd_ptr_r[AW-1:0]];
  end

`ifdef FP_ISSUE_STATS_EN
  logic [31:0] stat_issued_r;
  logic [15:0] stat_special_r;
  logic        special_s;

  // A pair is special when either operand is infinity or NaN (exc MSB set).
  always_comb begin
    special_s = unp_a_s[EXC_LSB+1] || unp_b_s[EXC_LSB+1];
  end

  // Counters survive flush and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_r  <= 32'd0;
      stat_special_r <= 16'd0;
    end else if (!flush) begin
      if (pop_s) begin
        stat_issued_r <= stat_issued_r + 32'd1;
      end
      if (push_s && special_s) begin
        stat_special_r <= stat_special_r + 16'd1;
      end
    end
  end

  assign stat_issued  = stat_issued_r;
  assign stat_special = stat_special_r;
`endif

endmodule

// File: tb/tb_fp_add_issue.sv
// Self-checking bench for fp_add_issue: directed corner cases plus randomized
// traffic against a queue-based reference model.
module tb_fp_add_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct {
    bit        sub;
    bit [33:0] a;
    bit [33:0] b;
    bit [3:0]  tag;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_sub, out_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        in_ready, out_valid, out_sub;
  logic [33:0] out_a, out_b;
  logic [3:0]  out_tag;
  logic [2:0]  level;
`ifdef FP_ISSUE_STATS_EN
  logic [31:0] stat_issued;
  logic [15:0] stat_special;
  int          m_issued, m_special;
`endif

  int    n_cmp = 0;
  int    n_fail = 0;
  pair_t model_q[$];

  fp_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sub(out_sub),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
`ifdef FP_ISSUE_STATS_EN
    .stat_issued(stat_issued), .stat_special(stat_special),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  // Reference unpack from the classification rules on the raw fields.
  function automatic bit [33:0] ref_unpack(input bit [31:0] v);
    int unsigned e = v[30:23];
    int unsigned f = v[22:0];
    if (e == 0) return {2'b00, v[31], 31'd0};
    if (e == 255) return (f == 0) ? {2'b10, v} : {2'b11, v};
    return {2'b01, v};
  endfunction

  function automatic bit [31:0] rand_op();
    bit [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'h00;
      1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  // Advance one clock and update the model from the inputs as seen at the edge.
  task automatic tick();
    bit    do_push = in_valid && (model_q.size() < DEPTH);
    bit    do_pop  = out_ready && (model_q.size() > 0);
    pair_t p;
    p.sub = in_sub; p.a = ref_unpack(in_a); p.b = ref_unpack(in_b); p.tag = in_tag;
    @(posedge clk);
    if (rst || flush) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(p);
    end
`ifdef FP_ISSUE_STATS_EN
    if (rst) begin
      m_issued = 0; m_special = 0;
    end else if (!flush) begin
      if (do_pop) m_issued++;
      if (do_push && (p.a[33] || p.b[33])) m_special++;
    end
`endif
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input bit [31:0] a, input bit [31:0] b, input bit s, input bit [3:0] t);
    in_valid = v; in_a = a; in_b = b; in_sub = s; in_tag = t;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_status: in_ready=%b out_valid=%b level=%0d, want 1 0 0", in_ready, out_valid, level);
    end
    n_cmp++;
    if (out_a !== 34'd0 || out_b !== 34'd0 || out_sub !== 1'b0 || out_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h b=%h sub=%b tag=%h, want all 0", out_a, out_b, out_sub, out_tag);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_in(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'd3);
    tick();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_a !== 34'h1_3F800000 || out_b !== 34'h1_40000000 ||
        out_tag !== 4'd3 || out_sub !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pair: v=%b a=%h b=%h tag=%h sub=%b, want 1 13f800000 140000000 3 0",
               out_valid, out_a, out_b, out_tag, out_sub);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_drain: out_valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_classify();
    out_ready = 1'b0;
    set_in(1'b1, 32'h00000001, 32'h7F800000, 1'b1, 4'd5);
    tick();
    set_in(1'b1, 32'h7FC00000, 32'h80000000, 1'b0, 4'd6);
    tick();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    n_cmp++;
    if (out_a !== 34'h0_00000000 || out_b !== 34'h2_7F800000 || out_sub !== 1'b1) begin
      n_fail++;
      $display("FAIL class_denorm_inf: a=%h b=%h sub=%b, want 000000000 27f800000 1", out_a, out_b, out_sub);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_a !== 34'h3_7FC00000 || out_b !== 34'h0_80000000 || out_tag !== 4'd6) begin
      n_fail++;
      $display("FAIL class_nan_negzero: a=%h b=%h tag=%h, want 37fc00000 080000000 6", out_a, out_b, out_tag);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, rand_op(), rand_op(), 1'($urandom), 4'(i + 8));
      tick();
    end
    n_cmp++;
    if (level !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_status: level=%0d in_ready=%b out_valid=%b, want 4 0 1", level, in_ready, out_valid);
    end
    set_in(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'd15);
    tick(); tick();
    n_cmp++;
    if (level !== 3'd4 || model_q.size() != 4) begin
      n_fail++;
      $display("FAIL full_no_overwrite: level=%0d, want 4", level);
    end
    // Pop at full with in_valid still high: push must not sneak in this cycle.
    out_ready = 1'b1;
    tick();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    n_cmp++;
    if (level !== 3'd3) begin
      n_fail++;
      $display("FAIL full_pop_no_push: level=%0d, want 3", level);
    end
    for (int i = 0; i < 8 && out_valid; i++) begin
      n_cmp++;
      if (out_a !== model_q[0].a || out_b !== model_q[0].b || out_tag !== model_q[0].tag || out_sub !== model_q[0].sub) begin
        n_fail++;
        $display("FAIL full_drain: tag=%h a=%h b=%h, want tag=%h a=%h b=%h",
                 out_tag, out_a, out_b, model_q[0].tag, model_q[0].a, model_q[0].b);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || model_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_empty: out_valid=%b model=%0d, want 0 0", out_valid, model_q.size());
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, rand_op(), rand_op(), 1'($urandom), 4'(i));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, rand_op(), rand_op(), 1'($urandom), 4'(i + 2));
      n_cmp++;
      if (level !== 3'd2 || out_tag !== model_q[0].tag || out_a !== model_q[0].a || out_b !== model_q[0].b) begin
        n_fail++;
        $display("FAIL b2b_step%0d: level=%0d tag=%h a=%h, want 2 %h %h", i, level, out_tag, out_a,
                 model_q[0].tag, model_q[0].a);
      end
      tick();
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    tick(); tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rand_op(), rand_op(), 1'b0, 4'(i));
      tick();
    end
    flush = 1'b1;
    set_in(1'b1, 32'h40400000, 32'h40400000, 1'b1, 4'd9);
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    n_cmp++;
    if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: level=%0d out_valid=%b in_ready=%b, want 0 0 1", level, out_valid, in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_lost_pair: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_cmp++;
      if (level !== 3'(model_q.size()) || out_valid !== (model_q.size() > 0) ||
          in_ready !== (model_q.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL rand_status c=%0d: level=%0d v=%b r=%b, want level=%0d", c, level, out_valid, in_ready, model_q.size());
      end
      if (model_q.size() > 0) begin
        n_cmp++;
        if (out_a !== model_q[0].a || out_b !== model_q[0].b || out_tag !== model_q[0].tag || out_sub !== model_q[0].sub) begin
          n_fail++;
          $display("FAIL rand_head c=%0d: a=%h b=%h tag=%h sub=%b, want %h %h %h %b", c, out_a, out_b, out_tag,
                   out_sub, model_q[0].a, model_q[0].b, model_q[0].tag, model_q[0].sub);
        end
      end
      set_in(($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom), 4'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 63) == 0);
      tick();
      flush = 1'b0;
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    out_ready = 1'b0;
  endtask

`ifdef FP_ISSUE_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) set_in(1'b1, 32'h7F800000, 32'h3F800000, 1'b0, 4'(i));
      else if (i == 3) set_in(1'b1, 32'h3F800000, 32'h7FC00001, 1'b0, 4'(i));
      else set_in(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'(i));
      tick();
    end
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    tick(); tick();
    n_cmp++;
    if (stat_issued !== 32'd5 || stat_special !== 16'd2 || m_issued != 5 || m_special != 2) begin
      n_fail++;
      $display("FAIL stats_count: issued=%0d special=%0d, want 5 2", stat_issued, stat_special);
    end
    do_reset();
    n_cmp++;
    if (stat_issued !== 32'd0 || stat_special !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: issued=%0d special=%0d, want 0 0", stat_issued, stat_special);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_classify();
    test_full();
    test_back_to_back();
    test_flush();
    test_random();
`ifdef FP_ISSUE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
